mem_access_stage: RTL and testbench
===================================

# mem_access_stage

MEM stage of the five-stage MIPS pipeline: consumes the EX/MEM pipeline register and performs the load/store on a req/ack data-memory bus. It stalls the upstream pipeline while an access is outstanding and loads the MEM/WB register. It also exposes the MEM-stage forwarding and hazard signals to the forwarding unit. Misaligned accesses and accesses that never receive an ack are dropped and reported.

## Interface
- TIMEOUT, 16: number of BUSY cycles without an ack before the access is aborted; minimum 1.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- ex_mem_mem_to_reg_wr  in  1  load: writeback data comes from memory.
- ex_mem_mem_wr_en  in  1  store.
- ex_mem_reg_wr_en  in  1  register write enable.
- ex_mem_reg_wr_addr  in  5  destination register.
- ex_mem_alu_result  in  32  effective address, or the ALU result for non-memory ops.
- ex_mem_mem_wr_data  in  32  store data.
- mem_alu_result  out  32  combinational copy of ex_mem_alu_result, for forwarding.
- mem_reg_wr_en, mem_reg_wr_addr  out  1/5  combinational copies, for hazard detection.
- mem_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- dmem_req, dmem_we  out  1  bus request and write strobe.
- dmem_addr, dmem_wdata  out  32  word address and write data.
- dmem_rdata  in  32  read data, valid in the cycle dmem_ack=1.
- dmem_ack  in  1  completes the current request in that cycle.
- mem_wb_reg_wr_en, mem_wb_reg_wr_addr, mem_wb_reg_wr_data  out  1/5/32  MEM/WB register.
- mem_addr_err  out  1  registered one-cycle pulse on a misaligned access.
- mem_timeout_err  out  1  sticky flag; cleared only by reset.

## Operation
- Definitions: access = ex_mem_mem_to_reg_wr | ex_mem_mem_wr_en. misaligned = access & (ex_mem_alu_result[1:0] != 0).
- FSM states:
  - IDLE (reset state).
  - BUSY: a request is outstanding.
- IDLE, access & !misaligned:
  - dmem_req=1 combinationally.
  - Bus is driven from the inputs: dmem_addr = ex_mem_alu_result; dmem_we = ex_mem_mem_wr_en; dmem_wdata = ex_mem_mem_wr_data.
  - With dmem_ack: the access completes this cycle and the FSM stays in IDLE.
  - Without dmem_ack: latch addr/we/wdata, load wait_cnt=0, go to BUSY.
- BUSY:
  - dmem_req=1 and the bus is driven from the latched registers, held stable until ack or abort.
  - With dmem_ack: complete and go to IDLE.
  - Without ack, wait_cnt==TIMEOUT-1: abort. Go to IDLE, set mem_timeout_err, drop the instruction.
  - Otherwise: wait_cnt+1.
- mem_stall = access & !misaligned & !dmem_ack & !(BUSY & wait_cnt==TIMEOUT-1). An ack in the abort cycle wins: normal completion, no error.
- MEM/WB update on every edge:
  - mem_stall=1: load a bubble (reg_wr_en=0, addr=0, data=0).
  - Misaligned or aborted: load a bubble. A misaligned access also sets mem_addr_err=1 for the next cycle and issues no dmem_req.
  - Otherwise (completed access or non-access op): reg_wr_en/addr are copied from EX/MEM; data = dmem_rdata if ex_mem_mem_to_reg_wr, else ex_mem_alu_result.
- Stores write no register unless ex_mem_reg_wr_en=1; the value is passed through unmodified.
- wait_cnt is $clog2(TIMEOUT+1) bits wide and never wraps.

## Timing
- Reset (reset=0, asynchronous): state IDLE; dmem_req=0 immediately, even mid-BUSY. Also cleared:
  - wait_cnt, latched bus registers.
  - All mem_wb_* outputs, mem_addr_err, mem_timeout_err.
- Zero-wait access (ack in issue cycle N): mem_stall=0 in N; mem_wb_* valid after edge N.
- k-wait access (ack in cycle N+k): mem_stall=1 in N..N+k-1 and 0 in N+k; MEM/WB holds bubbles through edge N+k-1 and the result after edge N+k.
- Timeout, no ack:
  - dmem_req=1 in cycles N..N+TIMEOUT.
  - mem_stall=1 in N..N+TIMEOUT-1.
  - Abort at edge N+TIMEOUT; mem_timeout_err=1 from then on.
- The next access may issue in the cycle right after completion, which gives back-to-back requests with no idle cycle.
- Forwarding outputs have zero latency; they are combinational from EX/MEM.

## Test plan
- ALU op (no access), alu_result=0x0000_0010, reg_wr_en=1, addr=5 -> no dmem_req, mem_stall=0; next cycle mem_wb = (1, 5, 0x10).
- Load at 0x100, ack in same cycle, rdata=0xDEAD_BEEF, dest=8 -> stall never 1; next cycle mem_wb_reg_wr_data=0xDEAD_BEEF, addr=8.
- Store at 0x200, data 0x1234_5678, ack after 3 cycles -> dmem_we=1 and addr/wdata stable for 4 cycles; mem_stall=1 for 3 cycles; MEM/WB shows bubbles then (0, x, 0x200).
- Load at 0x103 -> no dmem_req, no stall; mem_addr_err pulses for 1 cycle; MEM/WB bubble.
- TIMEOUT=4, load, no ack -> req high 5 cycles, stall high 4 cycles, mem_timeout_err=1 and stays 1; a following load with immediate ack completes normally.
- reset=0 during BUSY (second wait cycle) -> dmem_req and mem_stall drop asynchronously, all outputs 0; after release, a new load issues from IDLE.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage of the five-stage MIPS pipeline.
// Issues loads and stores on a req/ack data-memory bus and stalls the upstream
// pipeline while a request is outstanding. Loads the MEM/WB register and
// exposes the MEM-stage forwarding/hazard copies. Misaligned accesses and
// accesses that are never acknowledged within TIMEOUT busy cycles are dropped
// and reported.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_mem_mem_to_reg_wr,
    input  logic        ex_mem_mem_wr_en,
    input  logic        ex_mem_reg_wr_en,
    input  logic [4:0]  ex_mem_reg_wr_addr,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_mem_wr_data,
    output logic [31:0] mem_alu_result,
    output logic        mem_reg_wr_en,
    output logic [4:0]  mem_reg_wr_addr,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_wb_reg_wr_en,
    output logic [4:0]  mem_wb_reg_wr_addr,
    output logic [31:0] mem_wb_reg_wr_data,
    output logic        mem_addr_err,
    output logic        mem_timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // A word access must have its two low address bits clear.
    function automatic logic is_misaligned(input logic acc, input logic [1:0] lsb);
        return acc & (lsb != 2'b00);
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic [CNT_W-1:0]  wait_cnt_next_s;
    logic              latch_s;
    logic [31:0]       lat_addr_r;
    logic              lat_we_r;
    logic [31:0]       lat_wdata_r;

    logic              access_s;
    logic              misaligned_s;
    logic              issue_s;
    logic              busy_s;
    logic              last_wait_s;
    logic              abort_s;
    logic              stall_s;

    logic              wb_en_next_s;
    logic [4:0]        wb_addr_next_s;
    logic [31:0]       wb_data_next_s;

    logic              wb_en_r;
    logic [4:0]        wb_addr_r;
    logic [31:0]       wb_data_r;
    logic              addr_err_r;
    logic              timeout_err_r;

    assign access_s     = ex_mem_mem_to_reg_wr | ex_mem_mem_wr_en;
    assign misaligned_s = is_misaligned(access_s, ex_mem_alu_result[1:0]);
    assign issue_s      = access_s & ~misaligned_s;
    assign busy_s       = (state_r == ST_BUSY);
    assign last_wait_s  = busy_s & (wait_cnt_r == CNT_LAST);
    // An ack in the last wait cycle wins over the abort.
    assign abort_s      = last_wait_s & ~dmem_ack;
    // The stall is forced low while reset is held so the pipeline is released at once.
    assign stall_s      = reset & issue_s & ~dmem_ack & ~last_wait_s;

    // Forwarding / hazard copies have zero latency.
    assign mem_alu_result  = ex_mem_alu_result;
    assign mem_reg_wr_en   = ex_mem_reg_wr_en;
    assign mem_reg_wr_addr = ex_mem_reg_wr_addr;
    assign mem_stall       = stall_s;

    assign mem_wb_reg_wr_en   = wb_en_r;
    assign mem_wb_reg_wr_addr = wb_addr_r;
    assign mem_wb_reg_wr_data = wb_data_r;
    assign mem_addr_err       = addr_err_r;
    assign mem_timeout_err    = timeout_err_r;

    // State and wait counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= '0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
        end
    end

    // Next-state logic: enter BUSY on an unacknowledged issue, leave on ack or abort.
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        latch_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (issue_s && !dmem_ack) begin
                    state_next_s    = ST_BUSY;
                    wait_cnt_next_s = '0;
                    latch_s         = 1'b1;
                end else begin
                    state_next_s    = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (dmem_ack || last_wait_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_next_s    = ST_IDLE;
                wait_cnt_next_s = '0;
            end
        endcase
    end

    // Capture the bus request so it stays stable while waiting for the ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_addr_r  <= 32'h0000_0000;
            lat_we_r    <= 1'b0;
            lat_wdata_r <= 32'h0000_0000;
        end else if (latch_s) begin
            lat_addr_r  <= ex_mem_alu_result;
            lat_we_r    <= ex_mem_mem_wr_en;
            lat_wdata_r <= ex_mem_mem_wr_data;
        end else begin
            lat_addr_r  <= lat_addr_r;
            lat_we_r    <= lat_we_r;
            lat_wdata_r <= lat_wdata_r;
        end
    end

    // Bus drive: latched values while BUSY, EX/MEM values on a fresh issue, quiet in reset.
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 32'h0000_0000;
        dmem_wdata = 32'h0000_0000;
        if (!reset) begin
            dmem_req = 1'b0;
        end else if (busy_s) begin
            dmem_req   = 1'b1;
            dmem_we    = lat_we_r;
            dmem_addr  = lat_addr_r;
            dmem_wdata = lat_wdata_r;
        end else if (issue_s) begin
            dmem_req   = 1'b1;
            dmem_we    = ex_mem_mem_wr_en;
            dmem_addr  = ex_mem_alu_result;
            dmem_wdata = ex_mem_mem_wr_data;
        end else begin
            dmem_req = 1'b0;
        end
    end

    // MEM/WB next value: bubble while stalled or when the instruction is dropped.
    always_comb begin
        wb_en_next_s   = 1'b0;
        wb_addr_next_s = 5'd0;
        wb_data_next_s = 32'h0000_0000;
        if (stall_s || misaligned_s || abort_s) begin
            wb_en_next_s = 1'b0;
        end else begin
            wb_en_next_s   = ex_mem_reg_wr_en;
            wb_addr_next_s = ex_mem_reg_wr_addr;
            wb_data_next_s = ex_mem_mem_to_reg_wr ? dmem_rdata : ex_mem_alu_result;
        end
    end

    // MEM/WB pipeline register and error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_en_r       <= 1'b0;
            wb_addr_r     <= 5'd0;
            wb_data_r     <= 32'h0000_0000;
            addr_err_r    <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            wb_en_r       <= wb_en_next_s;
            wb_addr_r     <= wb_addr_next_s;
            wb_data_r     <= wb_data_next_s;
            addr_err_r    <= misaligned_s;
            timeout_err_r <= timeout_err_r | abort_s;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a table of single-cycle vectors,
// hand-written multi-cycle sequences, and randomized transactions checked
// against a transaction-level model of the stage.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        ex_mem_mem_to_reg_wr;
    logic        ex_mem_mem_wr_en;
    logic        ex_mem_reg_wr_en;
    logic [4:0]  ex_mem_reg_wr_addr;
    logic [31:0] ex_mem_alu_result;
    logic [31:0] ex_mem_mem_wr_data;
    logic [31:0] mem_alu_result;
    logic        mem_reg_wr_en;
    logic [4:0]  mem_reg_wr_addr;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        mem_wb_reg_wr_en;
    logic [4:0]  mem_wb_reg_wr_addr;
    logic [31:0] mem_wb_reg_wr_data;
    logic        mem_addr_err;
    logic        mem_timeout_err;

    int total = 0;
    int bad   = 0;
    logic exp_terr = 1'b0;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk                  (clk),
        .reset                (reset),
        .ex_mem_mem_to_reg_wr (ex_mem_mem_to_reg_wr),
        .ex_mem_mem_wr_en     (ex_mem_mem_wr_en),
        .ex_mem_reg_wr_en     (ex_mem_reg_wr_en),
        .ex_mem_reg_wr_addr   (ex_mem_reg_wr_addr),
        .ex_mem_alu_result    (ex_mem_alu_result),
        .ex_mem_mem_wr_data   (ex_mem_mem_wr_data),
        .mem_alu_result       (mem_alu_result),
        .mem_reg_wr_en        (mem_reg_wr_en),
        .mem_reg_wr_addr      (mem_reg_wr_addr),
        .mem_stall            (mem_stall),
        .dmem_req             (dmem_req),
        .dmem_we              (dmem_we),
        .dmem_addr            (dmem_addr),
        .dmem_wdata           (dmem_wdata),
        .dmem_rdata           (dmem_rdata),
        .dmem_ack             (dmem_ack),
        .mem_wb_reg_wr_en     (mem_wb_reg_wr_en),
        .mem_wb_reg_wr_addr   (mem_wb_reg_wr_addr),
        .mem_wb_reg_wr_data   (mem_wb_reg_wr_data),
        .mem_addr_err         (mem_addr_err),
        .mem_timeout_err      (mem_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mtr;
        logic        we;
        logic        rwe;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_stall;
        logic        e_wen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_aerr;
    } vec_t;

    typedef struct {
        logic        mtr;
        logic        we;
        logic        rwe;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          d;      // cycle offset of the ack; beyond TO means never
    } txn_t;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_ex(input logic mtr, input logic we, input logic rwe,
                            input logic [4:0] dest, input logic [31:0] alu,
                            input logic [31:0] wdata);
        ex_mem_mem_to_reg_wr = mtr;
        ex_mem_mem_wr_en     = we;
        ex_mem_reg_wr_en     = rwe;
        ex_mem_reg_wr_addr   = dest;
        ex_mem_alu_result    = alu;
        ex_mem_mem_wr_data   = wdata;
    endtask

    // Transaction-level model: an aligned access holds the bus until the ack
    // (or TO busy cycles), stalls every cycle but the last, and writes back
    // only if it completed. Called at posedge+1, returns at posedge+1.
    task automatic run_txn(input txn_t t);
        logic acc, mis, issue, tmo, done;
        int   last;
        acc   = t.mtr | t.we;
        mis   = acc && (t.alu[1:0] != 2'b00);
        issue = acc && !mis;
        tmo   = issue && (t.d > TO);
        last  = issue ? ((t.d < TO) ? t.d : TO) : 0;
        drive_ex(t.mtr, t.we, t.rwe, t.dest, t.alu, t.wdata);
        for (int i = 0; i <= last; i++) begin
            dmem_ack   = issue && (i == t.d);
            dmem_rdata = (issue && (i == t.d)) ? t.rdata : $urandom();
            #3;
            chk1("req", dmem_req, issue);
            chk1("stall", mem_stall, issue && (i < last));
            if (issue) begin
                chk32("bus_addr", dmem_addr, t.alu);
                chk1("bus_we", dmem_we, t.we);
                if (t.we) chk32("bus_wdata", dmem_wdata, t.wdata);
            end
            chk32("fwd_alu", mem_alu_result, t.alu);
            chk1("fwd_wen", mem_reg_wr_en, t.rwe);
            chk32("fwd_waddr", 32'(mem_reg_wr_addr), 32'(t.dest));
            @(posedge clk);
            #1;
            if ((i == last) && tmo) exp_terr = 1'b1;
            done = (i == last) && !tmo && !mis;
            chk1("wb_en", mem_wb_reg_wr_en, done ? t.rwe : 1'b0);
            chk32("wb_addr", 32'(mem_wb_reg_wr_addr), done ? 32'(t.dest) : 32'h0);
            chk32("wb_data", mem_wb_reg_wr_data, done ? (t.mtr ? t.rdata : t.alu) : 32'h0);
            chk1("addr_err", mem_addr_err, mis);
            chk1("timeout_err", mem_timeout_err, exp_terr);
        end
        dmem_ack = 1'b0;
    endtask

    vec_t vecs[10];
    txn_t t;

    initial begin
        reset = 1'b1;
        drive_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 5'd5,  32'h0000_0010, 32'h0,         1'b0, 32'h0,
                    1'b0, 1'b0, 1'b1, 5'd5,  32'h0000_0010, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 5'd8,  32'h0000_0100, 32'h0,         1'b1, 32'hDEAD_BEEF,
                    1'b1, 1'b0, 1'b1, 5'd8,  32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 5'd9,  32'h0000_0103, 32'h0,         1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 5'd7,  32'h0000_0003, 32'h0,         1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 5'd7,  32'h0000_0003, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 5'd3,  32'h0000_0204, 32'hCAFE_F00D, 1'b1, 32'h1111,
                    1'b1, 1'b0, 1'b0, 5'd3,  32'h0000_0204, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 5'd4,  32'h0000_0202, 32'hAA,        1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 5'd4,  32'h0000_0300, 32'h77,        1'b1, 32'h999,
                    1'b1, 1'b0, 1'b1, 5'd4,  32'h0000_0300, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 5'd2,  32'h0000_0008, 32'h0,         1'b1, 32'h55,
                    1'b1, 1'b0, 1'b0, 5'd2,  32'h0000_0055, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0,
                    1'b1, 1'b0, 1'b1, 5'd31, 32'h0,         1'b0};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 5'd1,  32'h0000_0001, 32'h0,         1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1};

        // Reset state.
        #2 reset = 1'b0;
        #1;
        chk1("rst_req", dmem_req, 1'b0);
        chk1("rst_stall", mem_stall, 1'b0);
        chk1("rst_wb_en", mem_wb_reg_wr_en, 1'b0);
        chk32("rst_wb_data", mem_wb_reg_wr_data, 32'h0);
        chk1("rst_addr_err", mem_addr_err, 1'b0);
        chk1("rst_timeout_err", mem_timeout_err, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        // Single-cycle vector table.
        for (int v = 0; v < 10; v++) begin
            drive_ex(vecs[v].mtr, vecs[v].we, vecs[v].rwe, vecs[v].dest,
                     vecs[v].alu, vecs[v].wdata);
            dmem_ack   = vecs[v].ack;
            dmem_rdata = vecs[v].rdata;
            #3;
            chk1("vec_req", dmem_req, vecs[v].e_req);
            chk1("vec_stall", mem_stall, vecs[v].e_stall);
            if (vecs[v].e_req) chk32("vec_bus_addr", dmem_addr, vecs[v].alu);
            @(posedge clk);
            #1;
            chk1("vec_wb_en", mem_wb_reg_wr_en, vecs[v].e_wen);
            chk32("vec_wb_addr", 32'(mem_wb_reg_wr_addr), 32'(vecs[v].e_waddr));
            chk32("vec_wb_data", mem_wb_reg_wr_data, vecs[v].e_wdata);
            chk1("vec_addr_err", mem_addr_err, vecs[v].e_aerr);
        end
        dmem_ack = 1'b0;

        // Store with three wait cycles, then back-to-back zero-wait load.
        t = '{1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0200, 32'h1234_5678, 32'h0, 3};
        run_txn(t);
        t = '{1'b1, 1'b0, 1'b1, 5'd12, 32'h0000_0400, 32'h0, 32'h0BAD_F00D, 0};
        run_txn(t);
        // Ack exactly in the abort cycle completes normally.
        t = '{1'b1, 1'b0, 1'b1, 5'd13, 32'h0000_0404, 32'h0, 32'h1357_9BDF, TO};
        run_txn(t);
        // No ack at all: abort, sticky timeout flag, then a normal load.
        t = '{1'b1, 1'b0, 1'b1, 5'd14, 32'h0000_0408, 32'h0, 32'h0, TO + 3};
        run_txn(t);
        t = '{1'b1, 1'b0, 1'b1, 5'd15, 32'h0000_040C, 32'h0, 32'h2468_ACE0, 0};
        run_txn(t);

        // Reset asserted in the second wait cycle of an outstanding load.
        drive_ex(1'b1, 1'b0, 1'b1, 5'd6, 32'h0000_0040, 32'h0);
        dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk1("busy_req", dmem_req, 1'b1);
        chk1("busy_stall", mem_stall, 1'b1);
        reset = 1'b0;
        #1;
        exp_terr = 1'b0;
        chk1("arst_req", dmem_req, 1'b0);
        chk1("arst_stall", mem_stall, 1'b0);
        chk1("arst_wb_en", mem_wb_reg_wr_en, 1'b0);
        chk32("arst_wb_data", mem_wb_reg_wr_data, 32'h0);
        chk1("arst_addr_err", mem_addr_err, 1'b0);
        chk1("arst_timeout_err", mem_timeout_err, 1'b0);
        drive_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        t = '{1'b1, 1'b0, 1'b1, 5'd10, 32'h0000_0044, 32'h0, 32'h7777_0001, 1};
        run_txn(t);

        // Randomized back-to-back transactions.
        for (int n = 0; n < 200; n++) begin
            int kind;
            kind    = int'($urandom_range(0, 2));
            t.mtr   = (kind == 1);
            t.we    = (kind == 2);
            t.rwe   = 1'($urandom_range(0, 1));
            t.dest  = 5'($urandom_range(0, 31));
            t.alu   = $urandom();
            if ($urandom_range(0, 3) != 0) t.alu[1:0] = 2'b00;
            t.wdata = $urandom();
            t.rdata = $urandom();
            t.d     = int'($urandom_range(0, TO + 2));
            run_txn(t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
